// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller.
// Holds the load/store operation codes, the controller state encoding,
// write-back constants and small decode helpers used by the controller
// and its lane aligner.
package mem_access_ctrl_pkg;

    // Load/store operation codes carried on aluop
    localparam logic [7:0] ALU_LB  = 8'b1110_0000;
    localparam logic [7:0] ALU_LH  = 8'b1110_0001;
    localparam logic [7:0] ALU_LW  = 8'b1110_0011;
    localparam logic [7:0] ALU_LBU = 8'b1110_0100;
    localparam logic [7:0] ALU_LHU = 8'b1110_0101;
    localparam logic [7:0] ALU_SB  = 8'b1110_1000;
    localparam logic [7:0] ALU_SH  = 8'b1110_1001;
    localparam logic [7:0] ALU_SW  = 8'b1110_1011;

    // Write-back constants
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b0_0000;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // True for any load or store operation
    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW,
            ALU_SB, ALU_SH, ALU_SW: is_mem_op = 1'b1;
            default:                is_mem_op = 1'b0;
        endcase
    endfunction

    // True for store operations
    function automatic logic is_store_op(input logic [7:0] op);
        case (op)
            ALU_SB, ALU_SH, ALU_SW: is_store_op = 1'b1;
            default:                is_store_op = 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        case (op)
            ALU_LH, ALU_LHU, ALU_SH: is_misaligned = addr_lo[0];
            ALU_LW, ALU_SW:          is_misaligned = |addr_lo;
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian byte-lane aligner.
// Ports:
//   aluop      - load/store operation code
//   addr_lo    - effective address bits [1:0]
//   store_data - store source register value
//   rdata      - bus read data
//   sel        - byte-lane select (bit 3 = bits [31:24] = address offset 0)
//   wdata_rep  - store data replicated across all lanes
//   load_data  - selected lane, sign- or zero-extended to 32 bits
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  byte_sel_s;
    logic [3:0]  half_sel_s;

    // Lane extraction and lane masks for byte and halfword accesses
    always_comb begin
        byte_s     = 8'h00;
        byte_sel_s = 4'b0000;
        case (addr_lo)
            2'b00: begin byte_s = rdata[31:24]; byte_sel_s = 4'b1000; end
            2'b01: begin byte_s = rdata[23:16]; byte_sel_s = 4'b0100; end
            2'b10: begin byte_s = rdata[15:8];  byte_sel_s = 4'b0010; end
            2'b11: begin byte_s = rdata[7:0];   byte_sel_s = 4'b0001; end
            default: begin byte_s = 8'h00;      byte_sel_s = 4'b0000; end
        endcase
        if (addr_lo[1]) begin
            half_s     = rdata[15:0];
            half_sel_s = 4'b0011;
        end else begin
            half_s     = rdata[31:16];
            half_sel_s = 4'b1100;
        end
    end

    // Per-operation lane select, store replication and load extension
    always_comb begin
        sel       = 4'b0000;
        wdata_rep = ZERO_WORD;
        load_data = ZERO_WORD;
        case (aluop)
            ALU_LB:  begin sel = byte_sel_s; load_data = {{24{byte_s[7]}}, byte_s}; end
            ALU_LBU: begin sel = byte_sel_s; load_data = {24'h00_0000, byte_s}; end
            ALU_LH:  begin sel = half_sel_s; load_data = {{16{half_s[15]}}, half_s}; end
            ALU_LHU: begin sel = half_sel_s; load_data = {16'h0000, half_s}; end
            ALU_LW:  begin sel = 4'b1111;    load_data = rdata; end
            ALU_SB:  begin sel = byte_sel_s; wdata_rep = {4{store_data[7:0]}}; end
            ALU_SH:  begin sel = half_sel_s; wdata_rep = {2{store_data[15:0]}}; end
            ALU_SW:  begin sel = 4'b1111;    wdata_rep = store_data; end
            default: begin sel = 4'b0000;    wdata_rep = ZERO_WORD; load_data = ZERO_WORD; end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller.
// ALU results pass straight through to MEM/WB. Loads and stores run as a
// req/ack transaction on the data bus (IDLE -> BUSY -> DONE) while the
// pipeline is stalled; DONE presents the extended load result.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   wd_i/wreg_i/wdata_i         - write-back controls and ALU result from EX/MEM
//   aluop_i/mem_addr_i/store_data_i - memory operation, address, store value
//   flush_i                     - discard the current instruction's result
//   wd_o/wreg_o/wdata_o         - write-back controls and data to MEM/WB
//   stall_req_o                 - hold the front of the pipeline
//   align_err_o/bus_err_o       - one-cycle misalignment / timeout pulses
//   dbus_*                      - data bus request side and response inputs
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_wdata_o,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_ack_i
);

    // Counter value seen on the last permitted wait cycle
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e           state_r, state_nxt_s;
    logic [TIMEOUT_W-1:0] cnt_r, cnt_nxt_s;
    logic [7:0]           op_r, op_nxt_s;
    logic [1:0]           addr_lo_r, addr_lo_nxt_s;
    logic                 discard_r, discard_nxt_s;
    logic [31:0]          result_r, result_nxt_s;
    logic                 req_r, req_nxt_s;
    logic                 we_r, we_nxt_s;
    logic [31:0]          addr_r, addr_nxt_s;
    logic [3:0]           sel_r, sel_nxt_s;
    logic [31:0]          wdata_r, wdata_nxt_s;
    logic                 align_err_r, align_err_nxt_s;
    logic                 bus_err_r, bus_err_nxt_s;

    logic [7:0]           lane_op_s;
    logic [1:0]           lane_addr_s;
    logic [3:0]           lane_sel_s;
    logic [31:0]          lane_wdata_s;
    logic [31:0]          lane_load_s;

    // Aligner sees the live instruction while idle and the captured one during a transfer
    always_comb begin
        if (state_r == ST_IDLE) begin
            lane_op_s   = aluop_i;
            lane_addr_s = mem_addr_i[1:0];
        end else begin
            lane_op_s   = op_r;
            lane_addr_s = addr_lo_r;
        end
    end

    mem_lane_align u_lane_align (
        .aluop      (lane_op_s),
        .addr_lo    (lane_addr_s),
        .store_data (store_data_i),
        .rdata      (dbus_rdata_i),
        .sel        (lane_sel_s),
        .wdata_rep  (lane_wdata_s),
        .load_data  (lane_load_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, register updates and MEM/WB outputs
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        op_nxt_s        = op_r;
        addr_lo_nxt_s   = addr_lo_r;
        discard_nxt_s   = discard_r;
        result_nxt_s    = result_r;
        req_nxt_s       = req_r;
        we_nxt_s        = we_r;
        addr_nxt_s      = addr_r;
        sel_nxt_s       = sel_r;
        wdata_nxt_s     = wdata_r;
        align_err_nxt_s = 1'b0;
        bus_err_nxt_s   = 1'b0;
        stall_req_o     = 1'b0;
        wd_o            = wd_i;
        wreg_o          = WRITE_DISABLE;
        wdata_o         = wdata_i;
        if (!rst) begin
            // Keep MEM/WB quiet while reset is held, even though inputs pass through
            wd_o    = NOP_REG_ADDR;
            wdata_o = ZERO_WORD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!is_mem_op(aluop_i)) begin
                        wreg_o = wreg_i & ~flush_i;
                    end else if (is_misaligned(aluop_i, mem_addr_i[1:0])) begin
                        align_err_nxt_s = 1'b1;
                    end else begin
                        stall_req_o   = 1'b1;
                        state_nxt_s   = ST_BUSY;
                        cnt_nxt_s     = '0;
                        discard_nxt_s = 1'b0;
                        op_nxt_s      = aluop_i;
                        addr_lo_nxt_s = mem_addr_i[1:0];
                        req_nxt_s     = 1'b1;
                        we_nxt_s      = is_store_op(aluop_i);
                        addr_nxt_s    = {mem_addr_i[31:2], 2'b00};
                        sel_nxt_s     = lane_sel_s;
                        wdata_nxt_s   = lane_wdata_s;
                    end
                end
                ST_BUSY: begin
                    stall_req_o = 1'b1;
                    // A flush never aborts the bus cycle; it only suppresses write-back
                    discard_nxt_s = discard_r | flush_i;
                    if (dbus_ack_i) begin
                        state_nxt_s  = ST_DONE;
                        result_nxt_s = lane_load_s;
                        req_nxt_s    = 1'b0;
                        we_nxt_s     = 1'b0;
                        addr_nxt_s   = ZERO_WORD;
                        sel_nxt_s    = 4'b0000;
                        wdata_nxt_s  = ZERO_WORD;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s   = ST_DONE;
                        discard_nxt_s = 1'b1;
                        bus_err_nxt_s = 1'b1;
                        req_nxt_s     = 1'b0;
                        we_nxt_s      = 1'b0;
                        addr_nxt_s    = ZERO_WORD;
                        sel_nxt_s     = 4'b0000;
                        wdata_nxt_s   = ZERO_WORD;
                    end else begin
                        cnt_nxt_s = cnt_r + TIMEOUT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                    if (is_store_op(op_r)) begin
                        wreg_o = WRITE_DISABLE;
                    end else begin
                        wreg_o  = wreg_i & ~discard_r & ~flush_i;
                        wdata_o = result_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Transfer bookkeeping, bus request registers and error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= '0;
            op_r        <= 8'h00;
            addr_lo_r   <= 2'b00;
            discard_r   <= 1'b0;
            result_r    <= ZERO_WORD;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= ZERO_WORD;
            sel_r       <= 4'b0000;
            wdata_r     <= ZERO_WORD;
            align_err_r <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            op_r        <= op_nxt_s;
            addr_lo_r   <= addr_lo_nxt_s;
            discard_r   <= discard_nxt_s;
            result_r    <= result_nxt_s;
            req_r       <= req_nxt_s;
            we_r        <= we_nxt_s;
            addr_r      <= addr_nxt_s;
            sel_r       <= sel_nxt_s;
            wdata_r     <= wdata_nxt_s;
            align_err_r <= align_err_nxt_s;
            bus_err_r   <= bus_err_nxt_s;
        end
    end

    assign dbus_req_o   = req_r;
    assign dbus_we_o    = we_r;
    assign dbus_addr_o  = addr_r;
    assign dbus_sel_o   = sel_r;
    assign dbus_wdata_o = wdata_r;
    assign align_err_o  = align_err_r;
    assign bus_err_o    = bus_err_r;

endmodule
